// File: rtl/bm_loader_if.sv
// Request, multiplier-load and response signals of the Booth-multiplier loader.
// The master drives requests, bm_done and bm_out; the slave is the loader.
interface bm_loader_if #(
   parameter int WIDTH = 8
);
   logic               req_valid;
   logic               req_ready;
   logic [WIDTH-1:0]   req_mcand;
   logic [WIDTH-1:0]   req_mplier;
   logic [WIDTH-1:0]   req_count;
   logic [WIDTH-1:0]   bm_A;
   logic               bm_start;
   logic               bm_done;
   logic [2*WIDTH-1:0] bm_out;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [2*WIDTH-1:0] rsp_product;
   logic               rsp_timeout;
   logic               busy;

   modport master (
      output req_valid, req_mcand, req_mplier, req_count, bm_done, bm_out, rsp_ready,
      input  req_ready, bm_A, bm_start, rsp_valid, rsp_product, rsp_timeout, busy
   );

   modport slave (
      input  req_valid, req_mcand, req_mplier, req_count, bm_done, bm_out, rsp_ready,
      output req_ready, bm_A, bm_start, rsp_valid, rsp_product, rsp_timeout, busy
   );
endinterface

// File: rtl/bm_loader.sv
// Loads a Booth multiplier over one shared bus (kick, mcand, mplier, count), then waits
// for its done flag with a timeout and holds the product until the consumer takes it.
module bm_loader #(
   parameter int WIDTH   = 8,
   parameter int GAP     = 1,
   parameter int TIMEOUT = 64
) (
   input logic        clk,
   input logic        rst_n,
   bm_loader_if.slave bus
);
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_GAP,
      ST_WAIT_DONE,
      ST_RESP
   } state_t;

   localparam logic [WIDTH-1:0] FULL_COUNT   = WIDTH'(WIDTH);
   localparam logic [3:0]       GAP_LAST     = 4'(GAP - 1);
   localparam logic [7:0]       TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t                  state;
   logic [1:0]              phase;
   logic [3:0]              gap_cnt;
   logic [7:0]              wait_cnt;
   logic signed [WIDTH-1:0] mcand;
   logic signed [WIDTH-1:0] mplier;
   logic [WIDTH-1:0]        count;

   // A zero iteration count means a full-width run.
   function automatic logic [WIDTH-1:0] norm_count(input logic [WIDTH-1:0] cnt);
      return (cnt == '0) ? FULL_COUNT : cnt;
   endfunction

   function automatic logic [WIDTH-1:0] load_word(input logic [1:0]              ph,
                                                  input logic signed [WIDTH-1:0] mc,
                                                  input logic signed [WIDTH-1:0] mp,
                                                  input logic [WIDTH-1:0]        cnt);
      logic [WIDTH-1:0] word;
      case (ph)
         2'd0:    word = '0;
         2'd1:    word = mc;
         2'd2:    word = mp;
         default: word = cnt;
      endcase
      return word;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         phase           <= 2'd0;
         gap_cnt         <= 4'd0;
         wait_cnt        <= 8'd0;
         bus.req_ready   <= 1'b1;
         bus.bm_A        <= '0;
         bus.bm_start    <= 1'b0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_product <= '0;
         bus.rsp_timeout <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  mcand         <= bus.req_mcand;
                  mplier        <= bus.req_mplier;
                  count         <= norm_count(bus.req_count);
                  phase         <= 2'd0;
                  bus.bm_A      <= '0;
                  bus.req_ready <= 1'b0;
                  bus.busy      <= 1'b1;
                  state         <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               bus.bm_start <= 1'b1;
               state        <= ST_STROBE;
            end
            ST_STROBE: begin
               bus.bm_start <= 1'b0;
               gap_cnt      <= 4'd0;
               state        <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= 4'd0;
                  if (phase == 2'd3) begin
                     bus.bm_A <= '0;
                     wait_cnt <= 8'd0;
                     state    <= ST_WAIT_DONE;
                  end else begin
                     phase    <= phase + 2'd1;
                     bus.bm_A <= load_word(phase + 2'd1, mcand, mplier, count);
                     state    <= ST_SETUP;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (bus.bm_done) begin
                  bus.rsp_product <= bus.bm_out;
                  bus.rsp_timeout <= 1'b0;
                  bus.rsp_valid   <= 1'b1;
                  state           <= ST_RESP;
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  // The multiplier never answered: report a timeout with a zero product.
                  bus.rsp_product <= '0;
                  bus.rsp_timeout <= 1'b1;
                  bus.rsp_valid   <= 1'b1;
                  state           <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bm_loader.sv
// Randomised bench for bm_loader: a slot-based reference model predicts the load bus,
// strobes, response timing and product for every cycle of each operation.
`timescale 1ns/1ps
module tb_bm_loader;
   localparam int W      = 8;
   localparam int G      = 1;
   localparam int T      = 64;
   localparam int SLOT   = 2 + G;
   localparam int N_WAIT = 4 * SLOT + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   bm_loader_if #(.WIDTH(W)) bus ();

   bm_loader #(.WIDTH(W), .GAP(G), .TIMEOUT(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
      chk({tag, "_bm_A"}, 64'(bus.bm_A), 64'(0));
      chk({tag, "_bm_start"}, 64'(bus.bm_start), 64'(0));
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
      chk({tag, "_rsp_product"}, 64'(bus.rsp_product), 64'(0));
      chk({tag, "_rsp_timeout"}, 64'(bus.rsp_timeout), 64'(0));
      chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
   endtask

   // Called at a negedge with the DUT idle. Cycle n counts negedges after the accepting edge:
   // phase p occupies n in [1+p*SLOT, (p+1)*SLOT], its strobe at offset 1; waiting starts at N_WAIT.
   // done_off < 0 or >= T means the multiplier never answers; abort_n > 0 resets at that cycle.
   task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mp, input logic [W-1:0] cnt,
                         input int done_off, input bit noise, input int hold, input int abort_n);
      logic [W-1:0]          words[4];
      logic signed [2*W-1:0] prod;
      logic [2*W-1:0]        exp_prod;
      bit                    exp_to;
      bit                    finished;
      int                    ph;
      int                    pos;
      words[0] = '0;
      words[1] = mc;
      words[2] = mp;
      words[3] = (cnt == '0) ? W'(W) : cnt;
      prod     = $signed(mc) * $signed(mp);
      exp_prod = '0;
      exp_to   = 1'b0;
      finished = 1'b0;

      bus.req_valid  = 1'b1;
      bus.req_mcand  = mc;
      bus.req_mplier = mp;
      bus.req_count  = cnt;
      chk("accept_ready", 64'(bus.req_ready), 64'(1));

      for (int n = 1; n <= N_WAIT + T && !finished; n++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (n == abort_n) begin
            rst_n       = 1'b0;
            bus.bm_done = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_reset("abort");
            return;
         end
         if (n < N_WAIT) begin
            ph  = (n - 1) / SLOT;
            pos = (n - 1) % SLOT;
            chk("load_bus", 64'(bus.bm_A), 64'(words[ph]));
            chk("load_strobe", 64'(bus.bm_start), 64'(pos == 1));
            bus.bm_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.bm_out  = (2*W)'($urandom);
         end else begin
            chk("wait_bus", 64'(bus.bm_A), 64'(0));
            chk("wait_strobe", 64'(bus.bm_start), 64'(0));
            bus.bm_done = (done_off >= 0) && (n == N_WAIT + done_off);
            bus.bm_out  = bus.bm_done ? prod : (2*W)'($urandom);
            if (bus.bm_done) begin
               finished = 1'b1;
               exp_prod = prod;
               exp_to   = 1'b0;
            end else if (n == N_WAIT + T - 1) begin
               finished = 1'b1;
               exp_prod = '0;
               exp_to   = 1'b1;
            end
         end
         chk("op_busy", 64'(bus.busy), 64'(1));
         chk("op_req_ready", 64'(bus.req_ready), 64'(0));
         chk("op_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      end

      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
         chk("rsp_product", 64'(bus.rsp_product), 64'(exp_prod));
         chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(exp_to));
         chk("rsp_req_ready", 64'(bus.req_ready), 64'(0));
         chk("rsp_bm_start", 64'(bus.bm_start), 64'(0));
         chk("rsp_bm_A", 64'(bus.bm_A), 64'(0));
         chk("rsp_busy", 64'(bus.busy), 64'(1));
         bus.bm_done    = (h < hold) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.bm_out     = (2*W)'($urandom);
         bus.req_valid  = (h < hold);
         bus.req_mcand  = W'($urandom);
         bus.req_mplier = W'($urandom);
         bus.req_count  = W'($urandom);
         bus.rsp_ready  = (h == hold);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("done_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("done_req_ready", 64'(bus.req_ready), 64'(1));
      chk("done_busy", 64'(bus.busy), 64'(0));
      chk("done_bm_start", 64'(bus.bm_start), 64'(0));
   endtask

   initial begin
      logic [W-1:0] mc;
      logic [W-1:0] mp;
      logic [W-1:0] cnt;
      bus.req_valid  = 1'b0;
      bus.req_mcand  = '0;
      bus.req_mplier = '0;
      bus.req_count  = '0;
      bus.bm_done    = 1'b0;
      bus.bm_out     = '0;
      bus.rsp_ready  = 1'b0;

      repeat (3) @(negedge clk);
      check_reset("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset("after_reset");

      // 4 x 2, count 8, done ten cycles after the last strobe
      run_op(8'd4, 8'd2, 8'd8, 8, 1'b0, 0, 0);
      // -3 x 5 with count 0 loaded as full width
      run_op(8'hFD, 8'd5, 8'd0, 8, 1'b0, 0, 0);
      // multiplier never answers
      run_op(8'd7, 8'd6, 8'd4, -1, 1'b0, 0, 0);
      // consumer stalls for 20 cycles while done toggles and a request waits
      run_op(8'd7, 8'd9, 8'd3, 3, 1'b0, 20, 0);
      // reset during the mplier phase, then a fresh 3 x 3
      run_op(8'd1, 8'd2, 8'd3, 5, 1'b0, 0, 2 * SLOT + 2);
      run_op(8'd3, 8'd3, 8'd3, 2, 1'b0, 0, 0);
      // spurious done pulses during the load phases
      run_op(8'h81, 8'h7F, 8'd5, 0, 1'b1, 1, 0);
      run_op(8'hFF, 8'hFF, 8'd0, T - 1, 1'b1, 0, 0);

      for (int i = 0; i < 20; i++) begin
         mc  = W'($urandom);
         mp  = W'($urandom);
         cnt = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
         run_op(mc, mp, cnt, int'($urandom_range(0, T + 4)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
